min_sec_countdown: RTL and testbench

MIN_SEC_COUNTDOWN -- requirements
Module: min_sec_countdown

---
 rtl/min_sec_countdown_pkg.sv | 19 +
 rtl/min_sec_countdown_digit.sv | 29 ++
 rtl/min_sec_countdown.sv | 95 +++++++++
 tb/tb_min_sec_countdown.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/min_sec_countdown_pkg.sv
// min_sec_countdown_pkg: shared state encoding, digit limits and clamp helper
package min_sec_countdown_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] UNITS_MAX    = 4'd9;
    localparam logic [3:0] MIN_TENS_MAX = 4'd5;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max);
        return (d > max) ? max : d;
    endfunction

endpackage

// File: rtl/min_sec_countdown_digit.sv
// bcd_down_digit: one BCD digit that loads a clamped value and counts down with borrow
module bcd_down_digit
    import min_sec_countdown_pkg::*;
#(
    parameter logic [3:0] MAX = UNITS_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic [3:0] value,
    output logic       borrow
);

    // a decrement at zero wraps to MAX and ripples a borrow to the next digit
    assign borrow = dec && (value == 4'd0);

    // digit register: load beats decrement, decrement at zero reloads MAX
    always_ff @(posedge clk) begin
        if (reset)
            value <= 4'd0;
        else if (load)
            value <= clamp_digit(load_val, MAX);
        else if (dec)
            value <= (value == 4'd0) ? MAX : value - 4'd1;
    end

endmodule

// File: rtl/min_sec_countdown.sv
// min_sec_countdown: MM:SS BCD countdown timer with load/start/pause control
module min_sec_countdown
    import min_sec_countdown_pkg::*;
#(
    parameter int TICK_DIV = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_min,
    input  logic [7:0] load_sec,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] sec_units,
    output logic [3:0] sec_tens,
    output logic [3:0] min_units,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       done
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    state_t        state, state_next;
    logic [PW-1:0] presc;
    logic          nonzero, last_sec, tick;
    logic          su_borrow, st_borrow, mu_borrow, unused_min_tens_borrow;

    assign nonzero  = |{min_tens, min_units, sec_tens, sec_units};
    assign last_sec = {min_tens, min_units, sec_tens, sec_units} == 16'h0001;
    // load and pause both pre-empt a tick landing on the same cycle
    assign tick     = (state == RUN) && !load && !pause && (presc == PMAX);

    // state register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // next state with priority load > pause > start > tick expiry
    always_comb begin
        state_next = state;
        if (load)
            state_next = IDLE;
        else if (pause)
            state_next = (state == RUN) ? PAUSE : state;
        else if (start && (state == IDLE || state == PAUSE))
            state_next = nonzero ? RUN : EXPIRED;
        else if (tick && last_sec)
            state_next = EXPIRED;
    end

    // prescaler advances only while running and holds through a pause
    always_ff @(posedge clk) begin
        if (reset || load || tick)
            presc <= '0;
        else if (state == RUN && !pause)
            presc <= presc + PW'(1);
    end

    // registered status outputs; done marks the tick that reaches 00:00
    always_ff @(posedge clk) begin
        if (reset) begin
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            running <= (state_next == RUN);
            done    <= tick && last_sec;
        end
    end

    bcd_down_digit #(.MAX(UNITS_MAX)) u_sec_units (
        .clk(clk), .reset(reset), .load(load), .load_val(load_sec[3:0]),
        .dec(tick), .value(sec_units), .borrow(su_borrow)
    );

    bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .reset(reset), .load(load), .load_val(load_sec[7:4]),
        .dec(su_borrow), .value(sec_tens), .borrow(st_borrow)
    );

    bcd_down_digit #(.MAX(UNITS_MAX)) u_min_units (
        .clk(clk), .reset(reset), .load(load), .load_val(load_min[3:0]),
        .dec(st_borrow), .value(min_units), .borrow(mu_borrow)
    );

    bcd_down_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk(clk), .reset(reset), .load(load), .load_val(load_min[7:4]),
        .dec(mu_borrow), .value(min_tens), .borrow(unused_min_tens_borrow)
    );

endmodule

// File: tb/tb_min_sec_countdown.sv
// tb_min_sec_countdown: scoreboard bench against a seconds-count reference model
module tb_min_sec_countdown;

    localparam int TD = 4;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_EXP = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1, load = 1'b0, start = 1'b0, pause = 1'b0;
    logic [7:0] load_min = 8'h00, load_sec = 8'h00;
    logic [3:0] sec_units, sec_tens, min_units, min_tens;
    logic       running, done;

    int n_checks = 0;
    int n_fail = 0;
    int m_state = S_IDLE;
    int m_secs = 0;
    int m_phase = 0;
    bit m_done = 1'b0;
    logic [17:0] exp_q[$];

    min_sec_countdown #(.TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset), .load(load), .load_min(load_min), .load_sec(load_sec),
        .start(start), .pause(pause), .sec_units(sec_units), .sec_tens(sec_tens),
        .min_units(min_units), .min_tens(min_tens), .running(running), .done(done)
    );

    always #5 clk = ~clk;

    function automatic int clamp_val(input logic [7:0] v);
        int t, u;
        t = (v[7:4] > 4'd5) ? 5 : int'(v[7:4]);
        u = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
        return t * 10 + u;
    endfunction

    function automatic logic [17:0] exp_vec();
        int m, s;
        m = m_secs / 60;
        s = m_secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), m_state == S_RUN, m_done};
    endfunction

    // reference model: remaining time held as a plain number of seconds
    task automatic model();
        m_done = 1'b0;
        if (reset) begin
            m_state = S_IDLE; m_secs = 0; m_phase = 0;
        end else if (load) begin
            m_secs = clamp_val(load_min) * 60 + clamp_val(load_sec);
            m_phase = 0; m_state = S_IDLE;
        end else if (pause) begin
            if (m_state == S_RUN) m_state = S_PAUSE;
        end else if (start && (m_state == S_IDLE || m_state == S_PAUSE)) begin
            m_state = (m_secs > 0) ? S_RUN : S_EXP;
        end else if (m_state == S_RUN) begin
            if (m_phase == TD - 1) begin
                m_phase = 0;
                m_secs--;
                if (m_secs == 0) begin
                    m_state = S_EXP;
                    m_done = 1'b1;
                end
            end else begin
                m_phase++;
            end
        end
    endtask

    task automatic step(input bit r, input bit l, input logic [7:0] lm, input logic [7:0] ls,
                        input bit s, input bit p);
        @(negedge clk);
        reset = r; load = l; load_min = lm; load_sec = ls; start = s; pause = p;
        model();
        exp_q.push_back(exp_vec());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 8'h00, 0, 0);
    endtask

    // monitor: one registered output word per clock, compared against the queue head
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [17:0] e, a;
            e = exp_q.pop_front();
            a = {min_tens, min_units, sec_tens, sec_units, running, done};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL outputs t=%0t got mm:ss=%h run=%b done=%b expected mm:ss=%h run=%b done=%b",
                         $time, a[17:2], a[1], a[0], e[17:2], e[1], e[0]);
            end
        end
    end

    initial begin
        step(1, 0, 8'h00, 8'h00, 0, 0);
        step(1, 0, 8'h00, 8'h00, 0, 0);
        idle(2);
        step(0, 1, 8'h00, 8'h03, 0, 0);
        step(0, 0, 8'h00, 8'h00, 1, 0);
        idle(16);
        step(0, 1, 8'h10, 8'h00, 0, 0);
        step(0, 0, 8'h00, 8'h00, 1, 0);
        idle(5);
        step(0, 1, 8'h01, 8'h00, 0, 0);
        step(0, 0, 8'h00, 8'h00, 1, 0);
        idle(5);
        step(0, 1, 8'h00, 8'h10, 0, 0);
        step(0, 0, 8'h00, 8'h00, 1, 0);
        idle(5);
        step(0, 0, 8'h00, 8'h00, 0, 1);
        idle(20);
        step(0, 0, 8'h00, 8'h00, 1, 0);
        idle(10);
        step(0, 1, 8'h7F, 8'hAC, 0, 0);
        idle(2);
        step(0, 1, 8'h00, 8'h00, 0, 0);
        step(0, 0, 8'h00, 8'h00, 1, 0);
        idle(5);
        step(0, 1, 8'h00, 8'h03, 0, 0);
        step(0, 0, 8'h00, 8'h00, 1, 0);
        idle(5);
        step(1, 0, 8'h00, 8'h00, 0, 0);
        idle(1);
        step(0, 1, 8'h00, 8'h05, 1, 0);
        idle(3);
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] lm, ls;
            lm = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 1));
            ls = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
            step($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0, lm, ls,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 24) == 0);
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending entries expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
